// File: rtl/game_ctrl.sv
// game_ctrl: Flappy Bird sequencer: START/GAME/DYING/OVER machine, click gating, current and best score
module game_ctrl #(
    parameter int HOLDOFF_CYCLES = 65_000_000,
    parameter int SCORE_W = 10,
    parameter int SCORE_MAX = 999
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mouse_left,
    input  logic               bird_collision,
    input  logic               pipe_collision,
    input  logic               pipe_passed,
    output logic [1:0]         state,
    output logic               mouse_left_game,
    output logic               game_rst,
    output logic               scroll_en,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] best_score
);
    localparam int CNT_W = HOLDOFF_CYCLES > 1 ? $clog2(HOLDOFF_CYCLES) : 1;
    typedef enum logic [1:0] {START = 2'd0, GAME = 2'd1, DYING = 2'd2, OVER = 2'd3} state_t;
    state_t st, st_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [SCORE_W-1:0] score_n, best_n;
    logic ml_d, armed, click, collide, mlg_n, grst_n;
    assign click = mouse_left & ~ml_d & armed;
    assign collide = bird_collision | pipe_collision;
    assign state = st;
    // Rising-edge detect; armed stays low until the button is seen released after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ml_d <= 1'b0;
            armed <= 1'b0;
        end else begin
            ml_d <= mouse_left;
            armed <= armed | ~mouse_left;
        end
    end
    // State, holdoff counter, scores and registered pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= START;
            cnt <= '0;
            score <= '0;
            best_score <= '0;
            mouse_left_game <= 1'b0;
            game_rst <= 1'b0;
            scroll_en <= 1'b0;
        end else begin
            st <= st_n;
            cnt <= cnt_n;
            score <= score_n;
            best_score <= best_n;
            mouse_left_game <= mlg_n;
            game_rst <= grst_n;
            scroll_en <= st_n == GAME;
        end
    end
    // Next state and pulse decode; collision outranks clicks and pipe passes in GAME
    always_comb begin
        st_n = st;
        cnt_n = cnt;
        score_n = score;
        best_n = best_score;
        mlg_n = 1'b0;
        grst_n = 1'b0;
        case (st)
            START: begin
                st_n = click ? GAME : START;
                mlg_n = click;
            end
            GAME: begin
                if (collide) begin
                    st_n = DYING;
                    cnt_n = CNT_W'(HOLDOFF_CYCLES - 1);
                end else begin
                    score_n = (pipe_passed && score < SCORE_W'(SCORE_MAX)) ? score + 1'b1 : score;
                    mlg_n = click;
                end
            end
            DYING: begin
                if (cnt == '0) begin
                    st_n = OVER;
                    best_n = score > best_score ? score : best_score;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            OVER: begin
                st_n = click ? START : OVER;
                grst_n = click;
                score_n = click ? '0 : score;
            end
        endcase
    end
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: vector table, hand sequences and random play checked against a behavioural model
module tb_game_ctrl;
    localparam int H = 16;
    localparam int SMAX = 5;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mouse_left = 1'b0;
    logic bird_collision = 1'b0;
    logic pipe_collision = 1'b0;
    logic pipe_passed = 1'b0;
    logic [1:0] state;
    logic mouse_left_game, game_rst, scroll_en;
    logic [9:0] score, best_score;
    int checks = 0;
    int errors = 0;
    int m_mode = 0;
    int m_left = 0;
    int m_score = 0;
    int m_best = 0;
    bit m_mlg, m_grst, m_prev, m_seen;

    typedef struct {
        bit r, ml, bc, pc, pp;
        int st, mlg, grst, scr, sc, best;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    game_ctrl #(.HOLDOFF_CYCLES(H), .SCORE_W(10), .SCORE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst), .mouse_left(mouse_left), .bird_collision(bird_collision),
        .pipe_collision(pipe_collision), .pipe_passed(pipe_passed), .state(state),
        .mouse_left_game(mouse_left_game), .game_rst(game_rst), .scroll_en(scroll_en),
        .score(score), .best_score(best_score)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game rules in plain terms: mode 0..3, dying countdown in cycles, button seen released since reset
    task automatic model(input bit r, input bit ml, input bit bc, input bit pc, input bit pp);
        bit click;
        if (r) begin
            m_mode = 0; m_left = 0; m_score = 0; m_best = 0;
            m_mlg = 0; m_grst = 0; m_prev = 0; m_seen = 0;
        end else begin
            click = ml && !m_prev && m_seen;
            m_mlg = 0;
            m_grst = 0;
            if (m_mode == 0) begin
                if (click) begin m_mode = 1; m_mlg = 1; end
            end else if (m_mode == 1) begin
                if (bc || pc) begin
                    m_mode = 2;
                    m_left = H;
                end else begin
                    if (pp && m_score < SMAX) m_score++;
                    m_mlg = click;
                end
            end else if (m_mode == 2) begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 3;
                    if (m_score > m_best) m_best = m_score;
                end
            end else if (click) begin
                m_mode = 0;
                m_grst = 1;
                m_score = 0;
            end
            m_prev = ml;
            m_seen = m_seen || !ml;
        end
    endtask

    task automatic step(input bit r, input bit ml, input bit bc, input bit pc, input bit pp);
        @(negedge clk);
        rst = r; mouse_left = ml; bird_collision = bc; pipe_collision = pc; pipe_passed = pp;
        @(posedge clk);
        model(r, ml, bc, pc, pp);
        #1;
        chk("state", state, m_mode);
        chk("mouse_left_game", mouse_left_game, m_mlg);
        chk("game_rst", game_rst, m_grst);
        chk("scroll_en", scroll_en, m_mode == 1);
        chk("score", score, m_score);
        chk("best_score", best_score, m_best);
        chk("pulse_overlap", mouse_left_game & game_rst, 0);
    endtask

    task automatic expect_out(input string tag, input int st, input int mlg, input int grst, input int sc, input int best);
        chk({tag, "_state"}, state, st);
        chk({tag, "_mlg"}, mouse_left_game, mlg);
        chk({tag, "_grst"}, game_rst, grst);
        chk({tag, "_score"}, score, sc);
        chk({tag, "_best"}, best_score, best);
    endtask

    function automatic vec_t v(bit r, bit ml, bit bc, bit pc, bit pp, int st, int mlg, int grst, int scr, int sc, int best);
        vec_t x;
        x.r = r; x.ml = ml; x.bc = bc; x.pc = pc; x.pp = pp;
        x.st = st; x.mlg = mlg; x.grst = grst; x.scr = scr; x.sc = sc; x.best = best;
        return x;
    endfunction

    initial begin
        int ml_r;
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0));
        for (int i = 0; i < 9; i++) tbl.push_back(v(0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        for (int i = 1; i <= 3; i++) tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 1, i, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 1, 0, 1, 3, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 1, 4, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 1, 5, 0));
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].ml, tbl[i].bc, tbl[i].pc, tbl[i].pp);
            chk($sformatf("row%0d_state", i), state, tbl[i].st);
            chk($sformatf("row%0d_mlg", i), mouse_left_game, tbl[i].mlg);
            chk($sformatf("row%0d_grst", i), game_rst, tbl[i].grst);
            chk($sformatf("row%0d_scroll", i), scroll_en, tbl[i].scr);
            chk($sformatf("row%0d_score", i), score, tbl[i].sc);
            chk($sformatf("row%0d_best", i), best_score, tbl[i].best);
        end
        step(0, 0, 1, 0, 0);
        expect_out("bird_hit", 2, 0, 0, 5, 0);
        chk("bird_hit_scroll", scroll_en, 0);
        for (int i = 1; i <= H; i++) begin
            step(0, i % 2 == 1, 0, 0, 0);
            expect_out($sformatf("dying%0d", i), i == H ? 3 : 2, 0, 0, 5, i == H ? 5 : 0);
        end
        step(0, 1, 0, 0, 0);
        expect_out("restart", 0, 0, 1, 0, 5);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        expect_out("relaunch", 1, 1, 0, 0, 5);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 1, 1);
        expect_out("priority", 2, 0, 0, 2, 5);
        chk("priority_scroll", scroll_en, 0);
        for (int i = 1; i <= H; i++) step(0, 0, 0, 0, 0);
        expect_out("over_keep_best", 3, 0, 0, 2, 5);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        expect_out("pre_rst", 1, 1, 0, 4, 5);
        step(1, 1, 0, 0, 0);
        expect_out("mid_rst", 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            expect_out("held_after_rst", 0, 0, 0, 0, 0);
        end
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        expect_out("repress", 1, 1, 0, 0, 0);
        ml_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) ml_r = 1 - ml_r;
            step($urandom_range(299) == 0, ml_r[0], $urandom_range(59) == 0,
                 $urandom_range(59) == 0, $urandom_range(5) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Top-level game sequencer for the Flappy Bird design. It owns the START/GAME/DYING/OVER state machine and converts raw mouse clicks into the gated pulses the bird physics block consumes: mouse_left_game while playing, game_rst on restart. It merges the bird boundary collision and the pipe collision into game-over detection, and it keeps the current and best score. The state output drives the renderer (title/over overlays) and the pipe scroller enable.

Parameters:
HOLDOFF_CYCLES, 65_000_000, number of clk cycles clicks are ignored after a collision (1 s at 65 MHz); must be >= 1
SCORE_W, 10, width of score and best_score
SCORE_MAX, 999, saturation value of score

Ports:
clk  input  1  system clock (65 MHz pixel clock domain)
rst  input  1  synchronous active-high reset
mouse_left  input  1  raw left-button level from the mouse controller, already in the clk domain
bird_collision  input  1  level from the bird physics block: bird touched the top or bottom of the screen
pipe_collision  input  1  level from the pipe block: bird overlaps a pipe
pipe_passed  input  1  one-cycle pulse each time the bird clears a pipe pair
state  output  2  current state: 0=START, 1=GAME, 2=DYING, 3=OVER
mouse_left_game  output  1  one-cycle click pulse to the bird block, emitted only for clicks accepted in START or GAME
game_rst  output  1  one-cycle pulse resetting the bird and pipe blocks for a new game
scroll_en  output  1  pipes scroll; high only in GAME
score  output  SCORE_W  pipes passed in the current game
best_score  output  SCORE_W  maximum score since rst

Behaviour:
- Reset is rst, synchronous, active-high; the clock is clk. All outputs and internal state are registered.
- While rst is high: state=START, mouse_left_game=0, game_rst=0, scroll_en=0, score=0, best_score=0, holdoff counter=0, mouse_left delay register=0.
- Click detection: click = mouse_left & ~mouse_left_d, where mouse_left_d is mouse_left registered once.
  - A button held through reset does not generate a click until it is released and pressed again.
- Latency: every output reflects the event in the cycle after it is sampled (one-cycle registered response).
- collide = bird_collision | pipe_collision.
- START:
  - scroll_en=0.
  - On click: next state=GAME and mouse_left_game=1 for exactly one cycle. This pulse is what launches the bird.
  - collide and pipe_passed are ignored.
- GAME:
  - scroll_en=1.
  - On pipe_passed: score increments by 1, saturating at SCORE_MAX.
  - On click: mouse_left_game pulses for one cycle.
  - On collide: next state=DYING, scroll_en=0, and the holdoff counter is loaded with HOLDOFF_CYCLES-1.
  - Simultaneous events in the same cycle: collide has priority. No mouse_left_game pulse is emitted and no score increment is applied.
- DYING:
  - scroll_en=0. Clicks are discarded and no pulses are emitted.
  - The counter decrements every cycle. When the counter is 0, next state=OVER; DYING therefore lasts exactly HOLDOFF_CYCLES cycles.
  - On the DYING->OVER transition: if score > best_score, best_score <= score.
  - score holds its value.
- OVER:
  - scroll_en=0. score and best_score hold.
  - On click: next state=START, game_rst=1 for exactly one cycle, and score<=0 in the same cycle.
  - This click does not produce mouse_left_game; a second click in START is required to start play.
- collide and pipe_passed have no effect in START, DYING and OVER.
- State encoding 3 is OVER and is never left except by click or rst. No illegal states exist in the 2-bit encoding.
- rst asserted mid-game (any state): immediate return to START with all reset values, including best_score=0.
  - game_rst is not pulsed by rst; downstream blocks receive rst directly.
- mouse_left_game and game_rst are never high in the same cycle.
- A mouse_left_game pulse is never emitted in a cycle where state is DYING or OVER.

Test Plan:
- Start-up: HOLDOFF_CYCLES=16. Release rst, wait 5 cycles, then raise mouse_left and hold it for 10 cycles -> exactly one mouse_left_game pulse, one cycle after the rise; state=1 and scroll_en=1 from that cycle; holding the button produces no further pulses.
- Scoring: in GAME, apply 3 pipe_passed pulses, then click -> score=3 and one mouse_left_game pulse. Separately, with SCORE_MAX=5, apply 7 pulses -> score saturates at 5.
- Collision priority: in GAME with score=2, assert pipe_collision, mouse_left rising edge and pipe_passed in the same cycle -> next cycle state=2, scroll_en=0, no mouse_left_game pulse, score remains 2.
- Holdoff: HOLDOFF_CYCLES=16. Click repeatedly throughout DYING -> state=2 for exactly 16 cycles, then 3; no pulses on either output; best_score=2 on entry to OVER.
- Restart: in OVER, click -> one game_rst pulse, state=0, score=0, best_score stays 2. Next click -> mouse_left_game pulse and state=1. Play to a score of 1 and collide -> best_score remains 2 after DYING.
- Mid-game reset: in GAME with score=4 and best_score=2, assert rst for one cycle -> state=0, score=0, best_score=0, all pulses 0. With the button held through rst, no click is detected until it is released and pressed again.
